// File: rtl/store_unit.sv
// store_unit: byte/half/word stores onto a single word-wide BRAM port.
// Word stores write in one cycle. Sub-word stores read the target word,
// merge the new bytes in per lane, then write it back.
// Only one store is in flight at a time, so there is no read-after-write
// hazard between consecutive stores to the same word.

// One byte lane of the write-back merge: keep the old byte or take the new one.
module store_lane (
  input  logic       en,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = en ? new_b : old_b;
endmodule

module store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_size,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_mem_write,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  // Only the byte-offset and word-index bits of the address matter;
  // higher bits alias onto the same BRAM words.
  typedef struct packed {
    logic [ADDR_WIDTH+1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            size;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic   accept, req_err;

  logic unused_addr_hi;
  assign unused_addr_hi = ^i_addr[31:ADDR_WIDTH+2];

  assign accept = i_valid && (state == IDLE);

  // Reserved size, odd halfword and non-word-aligned word are all rejected.
  assign req_err = (i_size == 2'd3) ||
                   ((i_size == 2'd1) && i_addr[0]) ||
                   ((i_size == 2'd2) && (i_addr[1:0] != 2'b00));

  // State register; reset aborts any in-flight store.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: good word stores go straight to WR, sub-word stores read first.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && !req_err) state_nxt = (i_size == 2'd2) ? WR : RD;
      RD:   state_nxt = WR;
      WR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch; inputs are only looked at on the accept cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       req_q <= '0;
    else if (accept) req_q <= '{addr: i_addr[ADDR_WIDTH+1:0], data: i_data, size: i_size};
  end

  // Completion / rejection pulses, one cycle after WR or after a bad accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= (state == WR);
      o_err  <= accept && req_err;
    end
  end

  // Per-lane merge of the read-back word with the store data.
  logic [NUM_LANES-1:0][7:0] old_lanes, mrg_lanes;
  assign old_lanes = i_mem_data;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LANE = 2'(l);
    logic       en;
    logic [7:0] nb;

    // Lane select and source byte for the latched size/offset.
    always_comb begin
      en = 1'b1;
      nb = req_q.data[8*l +: 8];
      unique case (req_q.size)
        2'd0: begin
          en = (req_q.addr[1:0] == LANE);
          nb = req_q.data[7:0];
        end
        2'd1: begin
          en = (req_q.addr[1] == LANE[1]);
          nb = LANE[0] ? req_q.data[15:8] : req_q.data[7:0];
        end
        default: begin
          en = 1'b1;
          nb = req_q.data[8*l +: 8];
        end
      endcase
    end

    store_lane u_lane (
      .en    (en),
      .old_b (old_lanes[l]),
      .new_b (nb),
      .out_b (mrg_lanes[l])
    );
  end

  // Port B drive: decoded from state so reset drops the write strobe at once.
  always_comb begin
    o_ready     = (state == IDLE);
    o_mem_write = (state == WR);
    o_mem_addr  = '0;
    o_mem_data  = '0;
    if (state != IDLE) o_mem_addr = {{(32-ADDR_WIDTH){1'b0}}, req_q.addr[ADDR_WIDTH+1:2]};
    if (state == WR)   o_mem_data = mrg_lanes;
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: a small BRAM model on port B, a word-array
// reference memory updated with plain shift/mask arithmetic, and per-store
// traces of when the unit read, wrote and pulsed done/err.
module tb_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_addr, i_data;
  logic [1:0]  i_size;
  logic        o_done, o_err;
  logic [31:0] o_mem_addr, o_mem_data, mem_rdata;
  logic        o_mem_write;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram    [0:4095];
  logic [31:0] ref_mem [0:4095];

  logic        pl_we = 1'b0;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_size      (i_size),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_mem_write (o_mem_write),
    .i_mem_data  (mem_rdata)
  );

  // BRAM model: synchronous read, write on o_mem_write, bench preload port.
  always @(posedge clk) begin
    if (pl_we) bram[pl_addr] <= pl_data;
    else if (o_mem_write) bram[o_mem_addr[11:0]] <= o_mem_data;
    mem_rdata <= bram[o_mem_addr[11:0]];
  end

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [31:0] d, input logic [1:0] s);
    logic [31:0] mask, val;
    int sh;
    if (s == 2'd2) return d;
    if (s == 2'd0) begin
      sh = int'(a & 32'd3) * 8;
      mask = 32'hFF << sh;
      val = (d & 32'hFF) << sh;
    end else begin
      sh = int'(a & 32'd2) * 8;
      mask = 32'hFFFF << sh;
      val = (d & 32'hFFFF) << sh;
    end
    return (old & ~mask) | val;
  endfunction

  // Present one request for a single cycle, then watch six cycles and
  // record what the unit did. Cycle 0 is the accept cycle.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           output int rd_c, output int wr_c, output int dn_c, output int er_c,
                           output int n_wr, output int n_rd,
                           output logic [31:0] wa, output logic [31:0] wd);
    rd_c = -1; wr_c = -1; dn_c = -1; er_c = -1; n_wr = 0; n_rd = 0; wa = '0; wd = '0;
    @(negedge clk);
    i_valid = 1'b1; i_addr = a; i_data = d; i_size = s;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (o_mem_write) begin n_wr++; wr_c = k; wa = o_mem_addr; wd = o_mem_data; end
      if (!o_ready && !o_mem_write) begin n_rd++; rd_c = k; end
      if (o_done) dn_c = k;
      if (o_err) er_c = k;
      if (k == 1) begin
        i_valid = 1'b0; i_addr = $urandom; i_data = $urandom; i_size = 2'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_data = '0; i_size = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_we = 1'b1; pl_addr = 12'(i); pl_data = $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_we = 1'b0;
    checks++;
    if ({o_ready, o_done, o_err, o_mem_write} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got rdy/done/err/wr=%b want 1000", {o_ready, o_done, o_err, o_mem_write});
    end
    checks++;
    if (o_mem_addr !== 32'h0 || o_mem_data !== 32'h0) begin
      errors++; $display("FAIL reset_mem: got addr=%h data=%h want 0/0", o_mem_addr, o_mem_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word;
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd;
    logic [31:0] wa, wd;
    run_store(32'h10, 32'hDEADBEEF, 2'd2, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[4] = 32'hDEADBEEF;
    checks++;
    if (wd !== 32'hDEADBEEF || wa !== 32'd4) begin
      errors++; $display("FAIL word_data: got %h@%0d want deadbeef@4", wd, wa);
    end
    checks++;
    if (wr_c !== 1 || dn_c !== 2 || n_rd !== 0 || n_wr !== 1) begin
      errors++; $display("FAIL word_timing: got wr=%0d done=%0d reads=%0d writes=%0d want 1 2 0 1", wr_c, dn_c, n_rd, n_wr);
    end
    checks++;
    if (bram[4] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_mem: got %h want deadbeef", bram[4]);
    end
  endtask

  task automatic test_byte;
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd;
    logic [31:0] wa, wd;
    run_store(32'h12, 32'h55, 2'd0, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[4] = ref_merge(ref_mem[4], 32'h12, 32'h55, 2'd0);
    checks++;
    if (wd !== 32'hDE55BEEF) begin
      errors++; $display("FAIL byte_data: got %h want de55beef", wd);
    end
    checks++;
    if (rd_c !== 1 || wr_c !== 2 || dn_c !== 3 || er_c !== -1) begin
      errors++; $display("FAIL byte_timing: got rd=%0d wr=%0d done=%0d err=%0d want 1 2 3 -1", rd_c, wr_c, dn_c, er_c);
    end
  endtask

  task automatic test_half;
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd;
    logic [31:0] wa, wd;
    run_store(32'h10, 32'h11223344, 2'd2, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[4] = 32'h11223344;
    run_store(32'h12, 32'hFFFFAABB, 2'd1, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[4] = ref_merge(ref_mem[4], 32'h12, 32'hFFFFAABB, 2'd1);
    checks++;
    if (wd !== 32'hAABB3344 || dn_c !== 3) begin
      errors++; $display("FAIL half_hi: got %h done=%0d want aabb3344 done=3", wd, dn_c);
    end
    run_store(32'h10, 32'h0000CCDD, 2'd1, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[4] = ref_merge(ref_mem[4], 32'h10, 32'h0000CCDD, 2'd1);
    checks++;
    if (wd !== 32'hAABBCCDD || bram[4] !== 32'hAABBCCDD) begin
      errors++; $display("FAIL half_lo: got wd=%h mem=%h want aabbccdd", wd, bram[4]);
    end
  endtask

  task automatic test_errors;
    logic [31:0] ea [3] = '{32'h13, 32'h11, 32'h10};
    logic [1:0]  es [3] = '{2'd1, 2'd2, 2'd3};
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd;
    logic [31:0] wa, wd;
    for (int i = 0; i < 3; i++) begin
      run_store(ea[i], 32'h12345678, es[i], rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
      checks++;
      if (er_c !== 1 || dn_c !== -1 || n_wr !== 0 || n_rd !== 0) begin
        errors++; $display("FAIL err_%0d: got err=%0d done=%0d writes=%0d busy=%0d want 1 -1 0 0", i, er_c, dn_c, n_wr, n_rd);
      end
      checks++;
      if (bram[4] !== ref_mem[4]) begin
        errors++; $display("FAIL err_mem_%0d: got %h want %h", i, bram[4], ref_mem[4]);
      end
    end
  endtask

  task automatic test_alias;
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd;
    logic [31:0] wa, wd;
    run_store(32'h4000, 32'hA5A5_0F0F, 2'd2, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[0] = 32'hA5A5_0F0F;
    checks++;
    if (wa !== 32'd0 || bram[0] !== 32'hA5A5_0F0F) begin
      errors++; $display("FAIL alias: got addr=%h mem=%h want 0 a5a50f0f", wa, bram[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] bd, exp_a;
    bd = $urandom;
    exp_a = ref_merge(ref_mem[8], 32'h21, 32'h77, 2'd0);
    @(negedge clk);
    i_valid = 1'b1; i_addr = 32'h21; i_data = 32'h77; i_size = 2'd0;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_mem_write !== 1'b0) begin
      errors++; $display("FAIL b2b_rd: got rdy=%b wr=%b want 0 0", o_ready, o_mem_write);
    end
    i_addr = 32'h24; i_data = bd; i_size = 2'd2;
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b0 || o_mem_write !== 1'b1 || o_mem_data !== exp_a) begin
      errors++; $display("FAIL b2b_wr: got rdy=%b wr=%b data=%h want 0 1 %h", o_ready, o_mem_write, o_mem_data, exp_a);
    end
    @(negedge clk);
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b1) begin
      errors++; $display("FAIL b2b_done: got rdy=%b done=%b want 1 1", o_ready, o_done);
    end
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_mem_write !== 1'b1 || o_mem_addr !== 32'd9 || o_mem_data !== bd) begin
      errors++; $display("FAIL b2b_second: got wr=%b addr=%h data=%h want 1 9 %h", o_mem_write, o_mem_addr, o_mem_data, bd);
    end
    @(negedge clk);
    ref_mem[8] = exp_a;
    ref_mem[9] = bd;
    checks++;
    if (o_done !== 1'b1 || bram[8] !== exp_a || bram[9] !== bd) begin
      errors++; $display("FAIL b2b_mem: got done=%b m8=%h m9=%h want 1 %h %h", o_done, bram[8], bram[9], exp_a, bd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd, seen;
    logic [31:0] wa, wd, nd;
    @(negedge clk);
    i_valid = 1'b1; i_addr = 32'h30; i_data = 32'hEE; i_size = 2'd0;
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_busy: got rdy=%b want 0", o_ready);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_mem_write !== 1'b0 || o_mem_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_async: got rdy=%b wr=%b addr=%h want 1 0 0", o_ready, o_mem_write, o_mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_done || o_err || o_mem_write) seen++;
    end
    checks++;
    if (seen !== 0 || bram[12] !== ref_mem[12]) begin
      errors++; $display("FAIL rstmid_drop: got activity=%0d mem=%h want 0 %h", seen, bram[12], ref_mem[12]);
    end
    nd = $urandom;
    run_store(32'h30, nd, 2'd2, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
    ref_mem[12] = nd;
    checks++;
    if (dn_c !== 2 || bram[12] !== nd) begin
      errors++; $display("FAIL rstmid_after: got done=%0d mem=%h want 2 %h", dn_c, bram[12], nd);
    end
  endtask

  task automatic test_random;
    int rd_c, wr_c, dn_c, er_c, n_wr, n_rd, idx;
    logic [31:0] wa, wd, a, d, exp;
    logic [1:0] s;
    for (int n = 0; n < 60; n++) begin
      a = $urandom & 32'hFFFF_C0FF;
      d = $urandom;
      s = 2'($urandom_range(0, 3));
      idx = ref_idx(a);
      run_store(a, d, s, rd_c, wr_c, dn_c, er_c, n_wr, n_rd, wa, wd);
      if (ref_err(a, s)) begin
        checks++;
        if (er_c !== 1 || dn_c !== -1 || n_wr !== 0 || n_rd !== 0) begin
          errors++; $display("FAIL rand_err a=%h s=%0d: got err=%0d done=%0d writes=%0d busy=%0d want 1 -1 0 0", a, s, er_c, dn_c, n_wr, n_rd);
        end
      end else begin
        exp = ref_merge(ref_mem[idx], a, d, s);
        ref_mem[idx] = exp;
        checks++;
        if (wd !== exp || wa !== 32'(idx)) begin
          errors++; $display("FAIL rand_data a=%h s=%0d: got %h@%0d want %h@%0d", a, s, wd, wa, exp, idx);
        end
        checks++;
        if (er_c !== -1 || n_wr !== 1 || wr_c !== (s == 2'd2 ? 1 : 2) || dn_c !== (s == 2'd2 ? 2 : 3) ||
            n_rd !== (s == 2'd2 ? 0 : 1)) begin
          errors++; $display("FAIL rand_timing a=%h s=%0d: got wr=%0d done=%0d reads=%0d err=%0d", a, s, wr_c, dn_c, n_rd, er_c);
        end
      end
      checks++;
      if (bram[idx] !== ref_mem[idx]) begin
        errors++; $display("FAIL rand_mem idx=%0d: got %h want %h", idx, bram[idx], ref_mem[idx]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_alias;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
